id_operand_scoreboard: RTL and testbench

//  Parametrised ID-stage operand unit: register file with WB-to-ID write-through bypass plus a
//  per-register pending-load scoreboard that replaces the single-cycle load-use detector.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/regfile_bypass.sv | 45 ++++
 rtl/id_operand_scoreboard.sv | 110 +++++++++++
 tb/tb_id_operand_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core package: architectural defaults and register constants.
// Imported by the ID-stage operand logic.
package cpu_pkg;

  localparam int XLEN_D   = 32;
  localparam int NREGS_D  = 32;
  localparam int AW_D     = 5;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_bypass.sv
// Register file with WB-to-ID write-through bypass.
// Register 0 reads as zero and ignores writes.
module regfile_bypass
  import cpu_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int AW    = AW_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rsAddr,
  input  logic [AW-1:0]   rtAddr,
  input  logic            wbEn,
  input  logic [AW-1:0]   wbAddr,
  input  logic [XLEN-1:0] wbData,
  output logic [XLEN-1:0] rsData,
  output logic [XLEN-1:0] rtData
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] mem [NREGS];
  logic            wbLive;

  assign wbLive = wbEn && (wbAddr != ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wbLive) begin
      mem[wbAddr] <= wbData;
    end
  end

  always_comb begin
    rsData = mem[rsAddr];
    rtData = mem[rtAddr];
    if (wbLive && wbAddr == rsAddr) rsData = wbData;
    if (wbLive && wbAddr == rtAddr) rtData = wbData;
    if (rsAddr == ZERO) rsData = '0;
    if (rtAddr == ZERO) rtData = '0;
  end

endmodule

// File: rtl/id_operand_scoreboard.sv
// ID-stage operand unit: bypassed regfile plus per-register
// pending-load scoreboard driving the ID stall.
module id_operand_scoreboard
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREGS  = NREGS_D,
  parameter int AW     = AW_D,
  parameter int PEND_W = 2,
  parameter int TOT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             issue_valid,
  input  logic             issue_is_load,
  input  logic [AW-1:0]    issue_dst,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             wb_is_load,
  output logic [XLEN-1:0]  rs_data,
  output logic [XLEN-1:0]  rt_data,
  output logic             stall,
  output logic             pc_if_write,
  output logic [TOT_W-1:0] loads_inflight
);

  localparam logic [AW-1:0]     ZERO = AW'(REG_ZERO);
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] PONE = PEND_W'(1);
  localparam logic [TOT_W-1:0]  TMAX = '1;

  logic [PEND_W-1:0] pend [NREGS];
  logic [NREGS-1:0]  ret;
  logic [NREGS-1:0]  inc;
  logic              blkRs;
  logic              blkRt;
  logic              dstFull;
  logic              incAny;
  logic              retAny;
  logic [TOT_W-1:0]  totCnt;

  regfile_bypass #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) uRegfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .rsAddr (rs_addr),
    .rtAddr (rt_addr),
    .wbEn   (wb_en),
    .wbAddr (wb_addr),
    .wbData (wb_data),
    .rsData (rs_data),
    .rtData (rt_data)
  );

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : gPend
      if (r == REG_ZERO) begin : gZero
        assign pend[r] = '0;
        assign ret[r]  = 1'b0;
        assign inc[r]  = 1'b0;
      end else begin : gReg
        logic [PEND_W-1:0] cnt;

        assign pend[r] = cnt;
        assign ret[r]  = wb_en && wb_is_load
                      && wb_addr == AW'(r) && cnt != '0;
        assign inc[r]  = issue_valid && !stall && issue_is_load
                      && issue_dst == AW'(r);

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) cnt <= '0;
          else if (inc[r] && !ret[r]) cnt <= cnt + PONE;
          else if (ret[r] && !inc[r]) cnt <= cnt - PONE;
        end
      end
    end
  endgenerate

  // The final retire of a register is bypassed, so it never stalls
  assign blkRs = rs_used && rs_addr != ZERO && pend[rs_addr] != '0
              && !(ret[rs_addr] && pend[rs_addr] == PONE);
  assign blkRt = rt_used && rt_addr != ZERO && pend[rt_addr] != '0
              && !(ret[rt_addr] && pend[rt_addr] == PONE);
  assign dstFull = issue_is_load && issue_dst != ZERO
                && pend[issue_dst] == PMAX;

  assign stall       = issue_valid && (blkRs || blkRt || dstFull);
  assign pc_if_write = ~stall;

  assign incAny = |inc;
  assign retAny = |ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) totCnt <= '0;
    else if (incAny && !retAny && totCnt != TMAX) totCnt <= totCnt + 1'b1;
    else if (retAny && !incAny && totCnt != '0) totCnt <= totCnt - 1'b1;
  end

  assign loads_inflight = totCnt;

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed bench for id_operand_scoreboard.
// Hand-computed expectations, one checking task.
module tb_id_operand_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, issue_dst, wb_addr;
  logic        rs_used, rt_used, issue_valid, issue_is_load;
  logic        wb_en, wb_is_load;
  logic [31:0] wb_data;
  logic [31:0] rs_data, rt_data;
  logic        stall, pc_if_write;
  logic [3:0]  loads_inflight;

  int nChecks = 0;
  int nPass   = 0;

  id_operand_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_used        (rs_used),
    .rt_used        (rt_used),
    .issue_valid    (issue_valid),
    .issue_is_load  (issue_is_load),
    .issue_dst      (issue_dst),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .wb_is_load     (wb_is_load),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .stall          (stall),
    .pc_if_write    (pc_if_write),
    .loads_inflight (loads_inflight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic idle();
    rs_addr = '0; rt_addr = '0; rs_used = 0; rt_used = 0;
    issue_valid = 0; issue_is_load = 0; issue_dst = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0; wb_is_load = 0;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issueLoad(input logic [4:0] d);
    idle();
    issue_valid = 1; issue_is_load = 1; issue_dst = d;
  endtask

  task automatic wbLoad(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_is_load = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    rst_n = 1;
    tick();

    // 1: reset state
    rs_addr = 5; rs_used = 1; issue_valid = 1;
    #1;
    chk("rst_rs", rs_data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pcw", pc_if_write, 1);
    chk("rst_loads", loads_inflight, 0);

    // 2: write-through bypass
    idle();
    rs_addr = 3; rs_used = 1;
    wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
    #1;
    chk("byp_rs", rs_data, 32'hDEADBEEF);
    tick();
    wb_en = 0; wb_data = '0;
    #1;
    chk("arr_rs", rs_data, 32'hDEADBEEF);

    // 3: load-use stall until retire
    issueLoad(4);
    #1;
    chk("ld4_nostall", stall, 0);
    tick();
    idle();
    issue_valid = 1; rt_addr = 4; rt_used = 1;
    #1;
    chk("ld4_loads", loads_inflight, 1);
    chk("ld4_stall1", stall, 1);
    chk("ld4_pcw", pc_if_write, 0);
    tick();
    chk("ld4_stall2", stall, 1);
    wbLoad(4, 32'h00001234);
    #1;
    chk("ld4_ret_stall", stall, 0);
    chk("ld4_ret_rt", rt_data, 32'h00001234);
    tick();
    wb_en = 0; wb_is_load = 0;
    #1;
    chk("ld4_after_loads", loads_inflight, 0);
    chk("ld4_after_stall", stall, 0);
    chk("ld4_after_rt", rt_data, 32'h00001234);

    // 4: two loads to r7
    issueLoad(7);
    tick();
    issueLoad(7);
    #1;
    chk("ld7_2nd_nostall", stall, 0);
    tick();
    idle();
    issue_valid = 1; rs_addr = 7; rs_used = 1;
    wbLoad(7, 32'h11);
    #1;
    chk("ld7_loads2", loads_inflight, 2);
    chk("ld7_ret1_stall", stall, 1);
    tick();
    wbLoad(7, 32'h22);
    #1;
    chk("ld7_loads1", loads_inflight, 1);
    chk("ld7_ret2_stall", stall, 0);
    chk("ld7_ret2_rs", rs_data, 32'h22);
    tick();
    idle();
    #1;
    chk("ld7_loads0", loads_inflight, 0);

    // 5: saturate pend[9]
    for (int i = 0; i < 3; i++) begin
      issueLoad(9);
      tick();
    end
    chk("ld9_loads3", loads_inflight, 3);
    issueLoad(9);
    #1;
    chk("ld9_full_stall", stall, 1);
    tick();
    chk("ld9_held", loads_inflight, 3);
    wbLoad(9, 32'h99);
    #1;
    chk("ld9_full_ret_stall", stall, 1);
    tick();
    chk("ld9_after_ret", loads_inflight, 2);
    wb_en = 0; wb_is_load = 0;
    #1;
    chk("ld9_refill_nostall", stall, 0);
    tick();
    chk("ld9_refill", loads_inflight, 3);
    idle();
    for (int i = 0; i < 3; i++) begin
      wbLoad(9, 32'h90 + i);
      tick();
    end
    idle();
    #1;
    chk("ld9_drained", loads_inflight, 0);

    // 6: register zero and async reset
    issueLoad(0);
    rs_addr = 0; rs_used = 1;
    #1;
    chk("r0_stall", stall, 0);
    tick();
    chk("r0_loads", loads_inflight, 0);
    idle();
    issue_valid = 1; rs_addr = 0; rs_used = 1;
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF0000;
    #1;
    chk("r0_rs", rs_data, 0);
    tick();
    wb_en = 0;
    #1;
    chk("r0_rs_arr", rs_data, 0);

    issueLoad(4);
    tick();
    issueLoad(4);
    tick();
    idle();
    // non-load write while pending keeps the stall
    issue_valid = 1; rt_addr = 4; rt_used = 1;
    wb_en = 1; wb_addr = 4; wb_data = 32'h5A5A;
    #1;
    chk("waw_stall", stall, 1);
    tick();
    wb_en = 0;
    #1;
    chk("waw_loads", loads_inflight, 2);
    chk("waw_stall2", stall, 1);
    chk("waw_data", rt_data, 32'h5A5A);
    #2;
    rst_n = 0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_loads", loads_inflight, 0);
    chk("arst_rt", rt_data, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_stall", stall, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
